// File: rtl/residue_saver_param_if.sv
// Decision/row-stream/readback bundle for residue_saver_param.
// slave = the saver, master = the upstream/downstream stages driving it.
interface residue_saver_param_if #(
  parameter int NUM_MODES = 4,
  parameter int BLK       = 16,
  parameter int FRAME_W   = 256,
  parameter int FRAME_H   = 256,
  parameter int PIX_W     = 9,
  parameter int SAD_W     = 16
);
  localparam int MBS_X  = FRAME_W / BLK;
  localparam int MBS_Y  = FRAME_H / BLK;
  localparam int MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
  localparam int ROW_W  = BLK * PIX_W;
  localparam int ADDR_W = $clog2(FRAME_H * MBS_X);
  localparam int MB_W   = (MBS_X * MBS_Y > 1) ? $clog2(MBS_X * MBS_Y) : 1;
  localparam int MBX_W  = (MBS_X > 1) ? $clog2(MBS_X) : 1;
  localparam int MBY_W  = (MBS_Y > 1) ? $clog2(MBS_Y) : 1;
  localparam int RI_W   = $clog2(BLK);

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_MODES*SAD_W-1:0] sads;
  logic [MBX_W-1:0]           mb_x;
  logic [MBY_W-1:0]           mb_y;
  logic                       mode_valid;
  logic [MODE_W-1:0]          mode;
  logic                       row_req;
  logic [RI_W-1:0]            row_idx;
  logic                       row_valid;
  logic [ROW_W-1:0]           row_data;
  logic                       done;
  logic                       err;
  logic [ADDR_W-1:0]          rd_addr;
  logic [ROW_W-1:0]           rd_data;
  logic [MB_W-1:0]            mt_addr;
  logic [MODE_W-1:0]          mt_data;

  modport slave (
    input  in_valid, sads, mb_x, mb_y, row_valid, row_data, rd_addr, mt_addr,
    output in_ready, mode_valid, mode, row_req, row_idx, done, err, rd_data, mt_data
  );
  modport master (
    output in_valid, sads, mb_x, mb_y, row_valid, row_data, rd_addr, mt_addr,
    input  in_ready, mode_valid, mode, row_req, row_idx, done, err, rd_data, mt_data
  );
endinterface

// File: rtl/residue_saver_param.sv
// Picks the minimum-SAD mode for a block, streams that mode's residue rows into a
// frame-sized buffer and logs the mode per block; both stores have registered readback.
module residue_saver_param #(
  parameter int NUM_MODES = 4,
  parameter int BLK       = 16,
  parameter int FRAME_W   = 256,
  parameter int FRAME_H   = 256,
  parameter int PIX_W     = 9,
  parameter int SAD_W     = 16
) (
  input logic                  clk,
  input logic                  reset,
  residue_saver_param_if.slave bus
);
  localparam int MBS_X     = FRAME_W / BLK;
  localparam int MBS_Y     = FRAME_H / BLK;
  localparam int MODE_W    = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;
  localparam int ROW_W     = BLK * PIX_W;
  localparam int ADDR_W    = $clog2(FRAME_H * MBS_X);
  localparam int MB_W      = (MBS_X * MBS_Y > 1) ? $clog2(MBS_X * MBS_Y) : 1;
  localparam int MBX_W     = (MBS_X > 1) ? $clog2(MBS_X) : 1;
  localparam int MBY_W     = (MBS_Y > 1) ? $clog2(MBS_Y) : 1;
  localparam int RI_W      = $clog2(BLK);
  localparam int BUF_DEPTH = FRAME_H * MBS_X;
  localparam int MT_DEPTH  = MBS_X * MBS_Y;

  typedef enum logic [1:0] {IDLE, SEARCH, WRITE} state_e;

  state_e                          state_q;
  logic [NUM_MODES-1:0][SAD_W-1:0] sads_q;
  logic [MBX_W-1:0]                mbx_q;
  logic [MBY_W-1:0]                mby_q;
  logic [MODE_W-1:0]               cnt_q, best_idx_q, mode_q;
  logic [SAD_W-1:0]                best_sad_q;
  logic [RI_W-1:0]                 row_q;
  logic                            in_ready_q, mode_valid_q, row_req_q, done_q, err_q;
  logic [ROW_W-1:0]                rd_data_q;
  logic [MODE_W-1:0]               mt_data_q;

  logic [ROW_W-1:0]  buf_mem [BUF_DEPTH];
  logic [MODE_W-1:0] mt_mem  [MT_DEPTH];

  // Strict less-than keeps the lower index on ties.
  logic [SAD_W-1:0]  cand_sad;
  logic              cand_win, last_cand, accept, in_range;
  logic [MODE_W-1:0] best_idx_d;
  logic [SAD_W-1:0]  best_sad_d;
  logic              mt_we, buf_we;
  logic [MB_W-1:0]   mt_waddr;
  logic [ADDR_W-1:0] buf_waddr;

  assign cand_sad   = sads_q[cnt_q];
  assign cand_win   = cand_sad < best_sad_q;
  assign best_idx_d = cand_win ? cnt_q : best_idx_q;
  assign best_sad_d = cand_win ? cand_sad : best_sad_q;
  assign last_cand  = (cnt_q == MODE_W'(NUM_MODES - 1));
  assign accept     = bus.in_valid & in_ready_q;
  assign in_range   = (int'(bus.mb_x) < MBS_X) && (int'(bus.mb_y) < MBS_Y);

  assign mt_we     = (state_q == SEARCH) && last_cand;
  assign mt_waddr  = MB_W'(int'(mby_q) * MBS_X + int'(mbx_q));
  assign buf_we    = (state_q == WRITE) && bus.row_valid && row_req_q;
  assign buf_waddr = ADDR_W'((int'(mby_q) * BLK + int'(row_q)) * MBS_X + int'(mbx_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sads_q       <= '0;
      mbx_q        <= '0;
      mby_q        <= '0;
      cnt_q        <= '0;
      best_idx_q   <= '0;
      best_sad_q   <= '0;
      mode_q       <= '0;
      row_q        <= '0;
      in_ready_q   <= 1'b1;
      mode_valid_q <= 1'b0;
      row_req_q    <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      mode_valid_q <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sads_q <= bus.sads;
            mbx_q  <= bus.mb_x;
            mby_q  <= bus.mb_y;
            if (!in_range) begin
              err_q <= 1'b1;
            end else begin
              best_idx_q <= '0;
              best_sad_q <= bus.sads[SAD_W-1:0];
              cnt_q      <= MODE_W'(1);
              in_ready_q <= 1'b0;
              state_q    <= SEARCH;
            end
          end
        end
        SEARCH: begin
          best_idx_q <= best_idx_d;
          best_sad_q <= best_sad_d;
          cnt_q      <= cnt_q + MODE_W'(1);
          if (last_cand) begin
            mode_q       <= best_idx_d;
            mode_valid_q <= 1'b1;
            row_req_q    <= 1'b1;
            row_q        <= '0;
            state_q      <= WRITE;
          end
        end
        WRITE: begin
          if (bus.row_valid) begin
            if (row_q == RI_W'(BLK - 1)) begin
              row_q      <= '0;
              row_req_q  <= 1'b0;
              done_q     <= 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              row_q <= row_q + RI_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage is never reset so it maps onto plain synchronous RAM.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[buf_waddr] <= bus.row_data;
  end

  always_ff @(posedge clk) begin
    if (mt_we) mt_mem[mt_waddr] <= best_idx_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= '0;
      mt_data_q <= '0;
    end else begin
      rd_data_q <= buf_mem[bus.rd_addr];
      mt_data_q <= mt_mem[bus.mt_addr];
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.mode_valid = mode_valid_q;
  assign bus.mode       = mode_q;
  assign bus.row_req    = row_req_q;
  assign bus.row_idx    = row_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.mt_data    = mt_data_q;
endmodule

// File: tb/tb_residue_saver_param.sv
// Directed bench: default 16x16/4-mode saver (dut_a) plus a 4x4/2-mode saver on a
// 12x16 frame (dut_b) whose 2-bit mb_x can carry the out-of-range column 3.
module tb_residue_saver_param;
  localparam int PW = 9, SW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  residue_saver_param_if #(.NUM_MODES(4), .BLK(16), .FRAME_W(256), .FRAME_H(256),
                           .PIX_W(PW), .SAD_W(SW)) ifa ();
  residue_saver_param_if #(.NUM_MODES(2), .BLK(4), .FRAME_W(12), .FRAME_H(16),
                           .PIX_W(PW), .SAD_W(SW)) ifb ();

  residue_saver_param #(.NUM_MODES(4), .BLK(16), .FRAME_W(256), .FRAME_H(256),
                        .PIX_W(PW), .SAD_W(SW)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  residue_saver_param #(.NUM_MODES(2), .BLK(4), .FRAME_W(12), .FRAME_H(16),
                        .PIX_W(PW), .SAD_W(SW)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Row whose every pixel equals v, n pixels wide.
  function automatic logic [159:0] rep(input int v, input int n);
    logic [159:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j*PW +: PW] = PW'(v);
    return r;
  endfunction

  task automatic a_req(input logic [63:0] s, input int x, input int y, input int exp_mode);
    int cyc;
    cyc = 0;
    ifa.sads = s; ifa.mb_x = 4'(x); ifa.mb_y = 4'(y); ifa.in_valid = 1'b1;
    tick;
    ifa.in_valid = 1'b0;
    chk("a_busy", ifa.in_ready, 0);
    while (!ifa.mode_valid && cyc < 20) begin tick; cyc++; end
    chk("a_mode_lat", cyc, 3);
    chk("a_mode", ifa.mode, exp_mode);
    chk("a_row_req", ifa.row_req, 1);
  endtask

  // Feeds rows base+r; returns early (rows 0..abort_at-1 accepted) when abort_at<16.
  task automatic a_rows(input int base, input int stall_after, input int stall_len, input int abort_at);
    int cyc;
    logic [159:0] t;
    cyc = 0;
    for (int r = 0; r < 16; r++) begin
      if (r == abort_at) begin ifa.row_valid = 1'b0; return; end
      t = rep(base + r, 16);
      ifa.row_data = t[143:0]; ifa.row_valid = 1'b1;
      tick; cyc++;
      if (r == stall_after) begin
        ifa.row_valid = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick; cyc++;
          chk("a_stall_idx", ifa.row_idx, r + 1);
        end
      end
    end
    ifa.row_valid = 1'b0;
    chk("a_done", ifa.done, 1);
    chk("a_done_lat", cyc, 16 + stall_len);
    chk("a_rdy_done", ifa.in_ready, 1);
    tick;
    chk("a_done_pulse", ifa.done, 0);
    chk("a_req_drop", ifa.row_req, 0);
  endtask

  task automatic a_read(input string tag, input int addr, input int v);
    ifa.rd_addr = 12'(addr);
    tick;
    chk(tag, ifa.rd_data, rep(v, 16));
  endtask

  initial begin
    logic [159:0] t;
    ifa.in_valid = 0; ifa.sads = '0; ifa.mb_x = '0; ifa.mb_y = '0; ifa.row_valid = 0;
    ifa.row_data = '0; ifa.rd_addr = '0; ifa.mt_addr = '0;
    ifb.in_valid = 0; ifb.sads = '0; ifb.mb_x = '0; ifb.mb_y = '0; ifb.row_valid = 0;
    ifb.row_data = '0; ifb.rd_addr = '0; ifb.mt_addr = '0;

    #12;
    chk("rst_in_ready", ifa.in_ready, 1);
    chk("rst_mode_valid", ifa.mode_valid, 0);
    chk("rst_mode", ifa.mode, 0);
    chk("rst_row_req", ifa.row_req, 0);
    chk("rst_done_err", {ifa.done, ifa.err}, 0);
    chk("rst_rd_mt", {ifa.rd_data, ifa.mt_data}, 0);
    #1 reset = 1'b0;

    // Block (2,1): SADs 40,12,30,12 -> mode 1 (tie with 3 goes low).
    a_req({16'd12, 16'd30, 16'd12, 16'd40}, 2, 1, 1);
    a_rows('h10, 99, 0, 16);
    ifa.mt_addr = 8'(16 + 2);
    tick;
    chk("a_mt_b1", ifa.mt_data, 1);
    for (int r = 0; r < 16; r++) a_read("a_buf_b1", (16 + r) * 16 + 2, 'h10 + r);

    // Block (3,1) with a 5-cycle stall after row 7: SADs 5,9,5,3 -> mode 3.
    a_req({16'd3, 16'd5, 16'd9, 16'd5}, 3, 1, 3);
    a_rows('h10, 7, 5, 16);
    for (int r = 0; r < 16; r += 5) a_read("a_buf_stall", (16 + r) * 16 + 3, 'h10 + r);

    // Reset while row 9 of block (2,1) is pending.
    a_req({16'd7, 16'd7, 16'd7, 16'd7}, 2, 1, 0);
    a_rows('h40, 99, 0, 9);
    chk("a_pre_abort_idx", ifa.row_idx, 9);
    reset = 1'b1;
    #1;
    chk("a_abort_req", ifa.row_req, 0);
    chk("a_abort_idx", ifa.row_idx, 0);
    chk("a_abort_rdy", ifa.in_ready, 1);
    chk("a_abort_mode", {ifa.mode_valid, ifa.mode}, 0);
    tick;
    reset = 1'b0;
    for (int r = 0; r < 16; r++)
      a_read("a_buf_abort", (16 + r) * 16 + 2, (r < 9) ? ('h40 + r) : ('h10 + r));
    ifa.mt_addr = 8'(18);
    tick;
    chk("a_mt_abort", ifa.mt_data, 0);

    // Fresh request after reset: block (0,0), SADs 3,2,1,0 -> mode 3.
    a_req({16'd0, 16'd1, 16'd2, 16'd3}, 0, 0, 3);
    a_rows('h20, 99, 0, 16);
    ifa.mt_addr = 8'(0);
    a_read("a_buf_b4", 15 * 16, 'h2f);
    chk("a_mt_b4", ifa.mt_data, 3);

    // dut_b: back-to-back blocks at (0,1), second accepted in the done cycle.
    ifb.sads = {16'd4, 16'd9}; ifb.mb_x = 2'd0; ifb.mb_y = 2'd1; ifb.in_valid = 1'b1;
    tick;
    ifb.in_valid = 1'b0;
    tick;
    chk("b_mv1", ifb.mode_valid, 1);
    chk("b_mode1", ifb.mode, 1);
    for (int r = 0; r < 4; r++) begin
      t = rep('h30 + r, 4);
      ifb.row_data = t[35:0]; ifb.row_valid = 1'b1;
      if (r == 3) begin
        ifb.sads = {16'd4, 16'd4}; ifb.mb_x = 2'd0; ifb.mb_y = 2'd1; ifb.in_valid = 1'b1;
      end
      tick;
    end
    ifb.row_valid = 1'b0;
    chk("b_done1", ifb.done, 1);
    chk("b_rdy_done", ifb.in_ready, 1);
    ifb.mt_addr = 4'd3;
    tick;
    ifb.in_valid = 1'b0;
    chk("b_b2b_accept", ifb.in_ready, 0);
    chk("b_mt_before", ifb.mt_data, 1);
    tick;
    chk("b_mv2", ifb.mode_valid, 1);
    chk("b_mode2", ifb.mode, 0);
    chk("b_mt_rbw", ifb.mt_data, 1);
    ifb.rd_addr = 6'd12;
    for (int r = 0; r < 4; r++) begin
      t = rep('h50 + r, 4);
      ifb.row_data = t[35:0]; ifb.row_valid = 1'b1;
      tick;
      if (r == 0) chk("b_buf_rbw", ifb.rd_data, rep('h30, 4));
      if (r == 1) chk("b_buf_new", ifb.rd_data, rep('h50, 4));
    end
    ifb.row_valid = 1'b0;
    chk("b_done2", ifb.done, 1);
    tick;
    chk("b_mt_after", ifb.mt_data, 0);

    // Out-of-range column on dut_b.
    ifb.sads = {16'd1, 16'd2}; ifb.mb_x = 2'd3; ifb.mb_y = 2'd0; ifb.in_valid = 1'b1;
    tick;
    ifb.in_valid = 1'b0;
    chk("b_err", ifb.err, 1);
    chk("b_err_rdy", ifb.in_ready, 1);
    chk("b_err_nomv", ifb.mode_valid, 0);
    tick;
    chk("b_err_pulse", ifb.err, 0);
    chk("b_err_nomv2", {ifb.mode_valid, ifb.row_req}, 0);
    chk("b_err_mt", ifb.mt_data, 0);
    chk("b_err_buf", ifb.rd_data, rep('h50, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
